// File: rtl/nes_audio_dac.sv
// nes_audio_dac: second-order sigma-delta modulator turning the NES APU mix into a PDM bit stream.
// Optional feature macro AUDIO_DCBLOCK_EN inserts a first-order DC-blocking high-pass before the modulator.
module nes_audio_dac #(
    parameter int IN_W     = 16,
    parameter int I1_W     = 20,
    parameter int I2_W     = 24,
    parameter int DC_SHIFT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cen,
    input  logic [IN_W-1:0] sample,
    input  logic            mute,
    output logic            audio_o,
    output logic            clip
);

    localparam logic [IN_W-1:0]        MIDSCALE = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [IN_W-1:0] FB_POS   = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] FB_NEG   = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [I1_W-1:0] I1_MAX   = {1'b0, {(I1_W-1){1'b1}}};
    localparam logic signed [I1_W-1:0] I1_MIN   = {1'b1, {(I1_W-1){1'b0}}};
    localparam logic signed [I2_W-1:0] I2_MAX   = {1'b0, {(I2_W-1){1'b1}}};
    localparam logic signed [I2_W-1:0] I2_MIN   = {1'b1, {(I2_W-1){1'b0}}};

    // The integrator sums assume headroom for the input and feedback swings.
    if (I1_W < IN_W + 2 || I2_W < I1_W + 1 || DC_SHIFT < 1 || DC_SHIFT > IN_W) begin : g_param_check
        $error("nes_audio_dac: unsupported parameter combination");
    end

    logic [IN_W-1:0]        x_raw;
    logic                   mute_q;
    logic signed [IN_W-1:0] x_c;
    logic signed [IN_W-1:0] x_m;
    logic signed [IN_W-1:0] fb;
    logic signed [I1_W-1:0] i1;
    logic signed [I1_W-1:0] i1_next;
    logic signed [I2_W-1:0] i2;
    logic signed [I2_W-1:0] i2_next;
    logic signed [I1_W:0]   sum1;
    logic signed [I2_W:0]   sum2;
    logic                   sat1;
    logic                   sat2;

    // Mute is registered alongside the sample so both take effect on the same following update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_raw  <= MIDSCALE;
            mute_q <= 1'b0;
        end else begin
            if (cen) begin
                x_raw <= sample;
            end
            mute_q <= mute;
        end
    end

    always_comb begin
        x_c = '0;
        if (!mute_q) begin
            x_c = $signed({~x_raw[IN_W-1], x_raw[IN_W-2:0]});
        end
    end

`ifdef AUDIO_DCBLOCK_EN
    localparam int Y_W = IN_W + 2;

    logic signed [IN_W-1:0] x_prev;
    logic signed [Y_W-1:0]  y;
    logic signed [Y_W-1:0]  y_shr;
    logic signed [Y_W:0]    y_sum;
    logic signed [Y_W-1:0]  y_next;
    logic                   y_fits;

    always_comb begin
        y_shr = y >>> DC_SHIFT;
        y_sum = {{3{x_c[IN_W-1]}}, x_c} - {{3{x_prev[IN_W-1]}}, x_prev}
              + {y[Y_W-1], y} - {y_shr[Y_W-1], y_shr};
        y_next = y_sum[Y_W-1:0];
        if (y_sum[Y_W] != y_sum[Y_W-1]) begin
            y_next = y_sum[Y_W] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
        end
    end

    // The blocker state advances only with new samples, so its pole is set in cen periods.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_prev <= '0;
            y      <= '0;
        end else if (cen) begin
            x_prev <= x_c;
            y      <= y_next;
        end
    end

    always_comb begin
        y_fits = (&y[Y_W-1:IN_W-1]) | ~(|y[Y_W-1:IN_W-1]);
        x_m    = y[IN_W-1:0];
        if (!y_fits) begin
            x_m = y[Y_W-1] ? FB_NEG : FB_POS;
        end
    end
`else
    always_comb begin
        x_m = x_c;
    end
`endif

    // Both integrators saturate instead of wrapping; a wrap would flip the loop's sign and lock it up.
    always_comb begin
        fb   = audio_o ? FB_POS : FB_NEG;
        sat1 = 1'b0;
        sat2 = 1'b0;

        sum1 = {i1[I1_W-1], i1}
             + {{(I1_W+1-IN_W){x_m[IN_W-1]}}, x_m}
             - {{(I1_W+1-IN_W){fb[IN_W-1]}}, fb};
        i1_next = sum1[I1_W-1:0];
        if (sum1[I1_W] != sum1[I1_W-1]) begin
            sat1    = 1'b1;
            i1_next = sum1[I1_W] ? I1_MIN : I1_MAX;
        end

        sum2 = {i2[I2_W-1], i2}
             + {{(I2_W+1-I1_W){i1_next[I1_W-1]}}, i1_next}
             - {{(I2_W+1-IN_W){fb[IN_W-1]}}, fb};
        i2_next = sum2[I2_W-1:0];
        if (sum2[I2_W] != sum2[I2_W-1]) begin
            sat2    = 1'b1;
            i2_next = sum2[I2_W] ? I2_MIN : I2_MAX;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i1      <= '0;
            i2      <= '0;
            audio_o <= 1'b0;
            clip    <= 1'b0;
        end else begin
            i1      <= i1_next;
            i2      <= i2_next;
            audio_o <= ~i2_next[I2_W-1];
            clip    <= sat1 | sat2;
        end
    end

endmodule

// File: tb/tb_nes_audio_dac.sv
// tb_nes_audio_dac: directed bench for nes_audio_dac (default build, DC blocker disabled).
module tb_nes_audio_dac;

    localparam longint I1_JUMP = 262144;
    localparam longint I2_JUMP = 4194304;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        cen_man  = 1'b0;
    logic        cen_auto = 1'b0;
    logic        cen_gen  = 1'b0;
    logic        mute     = 1'b0;
    logic [15:0] sample   = 16'h8000;
    logic        cen;
    logic        audio_o;
    logic        clip;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] sample;
        logic        mute;
        int          settle;
        int          window;
        int          lo;
        int          hi;
        bit          clip_allowed;
    } duty_vec_t;

    typedef struct {
        logic   audio;
        longint i1;
    } step_vec_t;

    duty_vec_t vecs[7];
    step_vec_t steps[7];

    assign cen = cen_auto ? cen_gen : cen_man;

    always #5 clock = ~clock;

    nes_audio_dac #(
        .IN_W(16),
        .I1_W(20),
        .I2_W(24),
        .DC_SHIFT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cen(cen),
        .sample(sample),
        .mute(mute),
        .audio_o(audio_o),
        .clip(clip)
    );

    // Free-running 1-in-4 sample strobe, used once the directed sequences are done.
    initial begin : cen_gen_proc
        int phase;
        phase = 0;
        forever begin
            @(negedge clock);
            cen_gen = (phase == 0);
            phase = (phase + 1) % 4;
        end
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input longint actual, input longint lo, input longint hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input duty_vec_t v, output int ones, output bit clip_seen, output bit wrapped);
        longint prev1, prev2, cur1, cur2;
        sample    = v.sample;
        mute      = v.mute;
        ones      = 0;
        clip_seen = 1'b0;
        wrapped   = 1'b0;
        repeat (v.settle) @(negedge clock);
        prev1 = longint'(dut.i1);
        prev2 = longint'(dut.i2);
        for (int n = 0; n < v.window; n++) begin
            @(negedge clock);
            ones += int'(audio_o);
            if (clip) clip_seen = 1'b1;
            cur1 = longint'(dut.i1);
            cur2 = longint'(dut.i2);
            if (cur1 - prev1 > I1_JUMP || prev1 - cur1 > I1_JUMP) wrapped = 1'b1;
            if (cur2 - prev2 > I2_JUMP || prev2 - cur2 > I2_JUMP) wrapped = 1'b1;
            prev1 = cur1;
            prev2 = cur2;
        end
    endtask

    initial begin
        int  ones;
        bit  clip_seen;
        bit  wrapped;

        // Duty targets: (x + 32768) / 65535 of the window, with the listed tolerance.
        vecs[0] = '{"midscale",      16'h8000, 1'b0,  100,  4096, 2040,  2056, 1'b0};
        vecs[1] = '{"three_quarter", 16'hC000, 1'b0,  500,  4096, 3052,  3092, 1'b0};
        vecs[2] = '{"quarter",       16'h4000, 1'b0,  500,  4096, 1004,  1044, 1'b0};
        vecs[3] = '{"full_scale",    16'hFFFF, 1'b0,  200, 10000, 9990, 10000, 1'b1};
        vecs[4] = '{"recover_mid",   16'h8000, 1'b0, 2000,  4096, 2007,  2089, 1'b1};
        vecs[5] = '{"muted",         16'hF000, 1'b1,  500,  4096, 2040,  2056, 1'b0};
        vecs[6] = '{"unmuted",       16'hF000, 1'b0,  500,  4096, 3820,  3860, 1'b1};

        // Hand-stepped modulator from reset with a midscale input.
        steps[0] = '{1'b1,  32768};
        steps[1] = '{1'b1,      1};
        steps[2] = '{1'b0, -32766};
        steps[3] = '{1'b1,      2};
        steps[4] = '{1'b0, -32765};
        steps[5] = '{1'b0,      3};
        steps[6] = '{1'b1,  32771};

        repeat (2) @(negedge clock);
        check_output("reset_audio", longint'(audio_o), 0);
        check_output("reset_clip", longint'(clip), 0);
        check_output("reset_i1", longint'(dut.i1), 0);
        check_output("reset_i2", longint'(dut.i2), 0);
        check_output("reset_x_raw", longint'(dut.x_raw), 32768);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            check_output($sformatf("step%0d_audio", k), longint'(audio_o), longint'(steps[k].audio));
            check_output($sformatf("step%0d_i1", k), longint'(dut.i1), steps[k].i1);
        end

        // Sample 0x0000 latched at edge 1 must first act at edge 2.
        pulse_reset();
        sample  = 16'h0000;
        cen_man = 1'b1;
        @(negedge clock);
        cen_man = 1'b0;
        check_output("lat_e1_audio", longint'(audio_o), 1);
        check_output("lat_e1_i1", longint'(dut.i1), 32768);
        @(negedge clock);
        check_output("lat_e2_audio", longint'(audio_o), 1);
        check_output("lat_e2_i1", longint'(dut.i1), -32767);
        @(negedge clock);
        check_output("lat_e3_audio", longint'(audio_o), 0);
        check_output("lat_e3_i1", longint'(dut.i1), -98302);
        check_output("lat_e3_i2", longint'(dut.i2), -131067);

        // cen and mute rising together: sample latched, mute zeroes its effect.
        pulse_reset();
        sample  = 16'h0000;
        cen_man = 1'b1;
        mute    = 1'b1;
        @(negedge clock);
        cen_man = 1'b0;
        check_output("mute_cen_x_raw", longint'(dut.x_raw), 0);
        check_output("mute_cen_e1_i1", longint'(dut.i1), 32768);
        @(negedge clock);
        check_output("mute_cen_e2_i1", longint'(dut.i1), 1);
        check_output("mute_cen_e2_audio", longint'(audio_o), 1);
        mute = 1'b0;

        pulse_reset();
        sample   = 16'h8000;
        cen_auto = 1'b1;
        for (int v = 0; v < 7; v++) begin
            apply_stimulus(vecs[v], ones, clip_seen, wrapped);
            check_range({vecs[v].name, "_duty"}, ones, vecs[v].lo, vecs[v].hi);
            check_output({vecs[v].name, "_wrap"}, longint'(wrapped), 0);
            if (!vecs[v].clip_allowed) begin
                check_output({vecs[v].name, "_clip"}, longint'(clip_seen), 0);
            end
        end

        // Asynchronous reset landing between clock edges.
        sample = 16'hC000;
        mute   = 1'b0;
        repeat (50) @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_output("async_reset_audio", longint'(audio_o), 0);
        check_output("async_reset_clip", longint'(clip), 0);
        check_output("async_reset_i1", longint'(dut.i1), 0);
        check_output("async_reset_i2", longint'(dut.i2), 0);
        check_output("async_reset_x_raw", longint'(dut.x_raw), 32768);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
